// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Request/response bundle between the two LSU-side masters and
//               the data-memory arbiter. Every vector carries both masters,
//               with master i in slice i.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 12
);

  // Request side, driven by the masters
  logic [1:0]            req_i;
  logic [1:0]            we_i;
  logic [2*ADDR_W-1:0]   addr_i;
  logic [2*N-1:0]        wdata_i;
  logic [2*(N/8)-1:0]    be_i;

  // Response side, driven by the arbiter
  logic [1:0]            gnt_o;
  logic [1:0]            rvalid_o;
  logic [2*N-1:0]        rdata_o;

  // Master view: issues requests, observes grants and read returns
  modport master (
    output req_i,
    output we_i,
    output addr_i,
    output wdata_i,
    output be_i,
    input  gnt_o,
    input  rvalid_o,
    input  rdata_o
  );

  // Arbiter view
  modport slave (
    input  req_i,
    input  we_i,
    input  addr_i,
    input  wdata_i,
    input  be_i,
    output gnt_o,
    output rvalid_o,
    output rdata_o
  );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master arbiter for the single data-memory/IO port.
//               Master 0 is the core load/store path, master 1 the debug /
//               program loader. One access is granted per cycle with
//               round-robin on conflict; read data is routed back to the
//               issuing master after a fixed memory latency. Per-master
//               saturating stall counters record cycles spent waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int N      = 32,  // data width
  parameter int ADDR_W = 12,  // memory address width
  parameter int RD_LAT = 1,   // memory read latency, 1..4
  parameter int CNT_W  = 16   // stall counter width
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  dmem_arbiter_if.slave             bus,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [N-1:0]              mem_wdata_o,
  output logic [N/8-1:0]            mem_be_o,
  input  wire logic [N-1:0]         mem_rdata_i,
  output logic [2*CNT_W-1:0]        stall_cnt_o
);

  localparam int BE_W = N / 8;

  // --------------------------------------------------------------------------
  // Arbitration state and combinational grant
  // --------------------------------------------------------------------------
  // last_gnt_q holds the index of the most recently granted master; a tie
  // goes to the other one. Resetting it to 1 lets master 0 win the first tie.
  logic       last_gnt_q;
  logic       last_gnt_d;
  logic [1:0] gnt;
  logic       sel;        // index of the granted master (valid when |gnt)
  logic       any_gnt;

  // Grant decode; forced low while reset is asserted so the port is quiet
  // even if requests are already pending.
  always_comb begin
    gnt = 2'b00;
    if (rst_ni) begin
      unique case (bus.req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign sel         = gnt[1];
  assign any_gnt     = |gnt;
  assign bus.gnt_o   = gnt;

  // Round-robin pointer follows every grant, holds otherwise
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (any_gnt) begin
      last_gnt_d = sel;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Command mux: the granted master's command goes to memory; with no grant
  // every memory-side output is driven to zero.
  // --------------------------------------------------------------------------
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [N-1:0]      sel_wdata;
  logic [BE_W-1:0]   sel_be;

  assign sel_we    = sel ? bus.we_i[1]                    : bus.we_i[0];
  assign sel_addr  = sel ? bus.addr_i[ADDR_W +: ADDR_W]   : bus.addr_i[0 +: ADDR_W];
  assign sel_wdata = sel ? bus.wdata_i[N +: N]            : bus.wdata_i[0 +: N];
  assign sel_be    = sel ? bus.be_i[BE_W +: BE_W]         : bus.be_i[0 +: BE_W];

  assign mem_en_o    = any_gnt;
  assign mem_we_o    = any_gnt & sel_we;
  assign mem_addr_o  = any_gnt ? sel_addr  : '0;
  assign mem_wdata_o = any_gnt ? sel_wdata : '0;
  assign mem_be_o    = any_gnt ? sel_be    : '0;

  // --------------------------------------------------------------------------
  // Read-return pipe
  // --------------------------------------------------------------------------
  // Stage 0 captures the command accepted this cycle; stage RD_LAT-1 is the
  // head and lines up with mem_rdata_i for that read. Only valid bits need a
  // reset: ids are don't-care whenever their valid bit is low.
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [RD_LAT-1:0] pipe_vld_d;
  logic [RD_LAT-1:0] pipe_id_q;
  logic [RD_LAT-1:0] pipe_id_d;
  logic              rd_accept;

  assign rd_accept = any_gnt & ~sel_we;

  // Shift the pipe by one stage, inserting the current accept at stage 0
  always_comb begin
    pipe_vld_d    = '0;
    pipe_id_d     = '0;
    pipe_vld_d[0] = rd_accept;
    pipe_id_d[0]  = sel;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  // Pipe valid bits: cleared by reset so in-flight reads are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
    end
  end

  // Pipe id bits: follow the valid bits, no reset needed
  always_ff @(posedge clk_i) begin
    pipe_id_q <= pipe_id_d;
  end

  logic head_vld;
  logic head_id;

  assign head_vld = pipe_vld_q[RD_LAT-1];
  assign head_id  = pipe_id_q[RD_LAT-1];

  // Per-master response: pulse rvalid and pass memory data only to the
  // owner of the head entry; the other master sees zeros.
  for (genvar k = 0; k < 2; k++) begin : g_resp
    logic hit;
    assign hit                    = head_vld & (head_id == 1'(k));
    assign bus.rvalid_o[k]        = hit;
    assign bus.rdata_o[k*N +: N]  = hit ? mem_rdata_i : '0;
  end

  // --------------------------------------------------------------------------
  // Stall counters: count cycles where a master requests but is not granted,
  // saturating at all-ones instead of wrapping.
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar k = 0; k < 2; k++) begin : g_stall
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stalled;

    assign stalled = bus.req_i[k] & ~gnt[k];

    // Next count: bump on a stalled cycle unless already saturated
    always_comb begin
      cnt_d = cnt_q;
      if (stalled && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stall_cnt_o[k*CNT_W +: CNT_W] = cnt_q;
  end

endmodule : dmem_arbiter
`default_nettype wire
